// File: rtl/res_station_array.sv
// Multi-entry reservation station: buffers dispatched instructions, snoops the CDB for
// pending operands and issues the oldest fully-ready entry to its functional unit.
module res_station_array #(
  parameter int DEPTH  = 4,
  parameter int XLEN   = 32,
  parameter int TAG_W  = 3,
  parameter int CTRL_W = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         alloc_valid,
  output logic                         alloc_ready,
  input  logic [CTRL_W-1:0]            alloc_ctrl,
  input  logic [TAG_W-1:0]             alloc_dest,
  input  logic                         alloc_rdy1,
  input  logic                         alloc_rdy2,
  input  logic [XLEN-1:0]              alloc_v1,
  input  logic [XLEN-1:0]              alloc_v2,
  input  logic [TAG_W-1:0]             alloc_t1,
  input  logic [TAG_W-1:0]             alloc_t2,
  input  logic                         cdb_valid,
  input  logic [TAG_W-1:0]             cdb_tag,
  input  logic [XLEN-1:0]              cdb_data,
  input  logic                         fu_ready,
  output logic                         issue_valid,
  output logic [CTRL_W-1:0]            issue_ctrl,
  output logic [XLEN-1:0]              issue_v1,
  output logic [XLEN-1:0]              issue_v2,
  output logic [TAG_W-1:0]             issue_dest,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0]  busy_q, busy_d;
  logic [DEPTH-1:0]  rdy1_q, rdy1_d;
  logic [DEPTH-1:0]  rdy2_q, rdy2_d;
  logic [CTRL_W-1:0] ctrl_q [DEPTH];
  logic [CTRL_W-1:0] ctrl_d [DEPTH];
  logic [TAG_W-1:0]  dest_q [DEPTH];
  logic [TAG_W-1:0]  dest_d [DEPTH];
  logic [XLEN-1:0]   v1_q   [DEPTH];
  logic [XLEN-1:0]   v1_d   [DEPTH];
  logic [XLEN-1:0]   v2_q   [DEPTH];
  logic [XLEN-1:0]   v2_d   [DEPTH];
  logic [TAG_W-1:0]  t1_q   [DEPTH];
  logic [TAG_W-1:0]  t1_d   [DEPTH];
  logic [TAG_W-1:0]  t2_q   [DEPTH];
  logic [TAG_W-1:0]  t2_d   [DEPTH];
  // older_q[j][i] set means entry j was allocated before entry i (valid while both busy)
  logic [DEPTH-1:0]  older_q [DEPTH];
  logic [DEPTH-1:0]  older_d [DEPTH];
  logic [CW-1:0]     count_q, count_d;

  logic [DEPTH-1:0]  eligible;
  logic              has_older;
  logic              sel_found;
  logic [IW-1:0]     sel_idx;
  logic              free_found;
  logic [IW-1:0]     free_idx;
  logic              issue_fire;
  logic              alloc_fire;

  always_comb begin
    eligible  = busy_q & rdy1_q & rdy2_q;
    has_older = 1'b0;
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      has_older = 1'b0;
      for (int j = 0; j < DEPTH; j++) begin
        if (eligible[j] && older_q[j][i]) has_older = 1'b1;
      end
      if (eligible[i] && !has_older) begin
        sel_found = 1'b1;
        sel_idx   = IW'(i);
      end
    end
  end

  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!busy_q[i]) begin
        free_found = 1'b1;
        free_idx   = IW'(i);
      end
    end
  end

  assign alloc_ready = (count_q < CW'(DEPTH));
  assign issue_fire  = sel_found & fu_ready;
  assign alloc_fire  = alloc_valid & alloc_ready & free_found;

  always_comb begin
    busy_d  = busy_q;
    rdy1_d  = rdy1_q;
    rdy2_d  = rdy2_q;
    ctrl_d  = ctrl_q;
    dest_d  = dest_q;
    v1_d    = v1_q;
    v2_d    = v2_q;
    t1_d    = t1_q;
    t2_d    = t2_q;
    older_d = older_q;
    count_d = count_q;

    for (int i = 0; i < DEPTH; i++) begin
      if (busy_q[i] && cdb_valid) begin
        if (!rdy1_q[i] && (t1_q[i] == cdb_tag)) begin
          rdy1_d[i] = 1'b1;
          v1_d[i]   = cdb_data;
        end
        if (!rdy2_q[i] && (t2_q[i] == cdb_tag)) begin
          rdy2_d[i] = 1'b1;
          v2_d[i]   = cdb_data;
        end
      end
    end

    if (issue_fire) busy_d[sel_idx] = 1'b0;

    // The allocated slot comes from registered busy state, so a slot freed this cycle is reused next cycle
    if (alloc_fire) begin
      busy_d[free_idx] = 1'b1;
      ctrl_d[free_idx] = alloc_ctrl;
      dest_d[free_idx] = alloc_dest;
      rdy1_d[free_idx] = alloc_rdy1 | (cdb_valid && (cdb_tag == alloc_t1));
      rdy2_d[free_idx] = alloc_rdy2 | (cdb_valid && (cdb_tag == alloc_t2));
      v1_d[free_idx]   = alloc_rdy1 ? alloc_v1 : cdb_data;
      v2_d[free_idx]   = alloc_rdy2 ? alloc_v2 : cdb_data;
      t1_d[free_idx]   = alloc_t1;
      t2_d[free_idx]   = alloc_t2;
      older_d[free_idx] = '0;
      for (int j = 0; j < DEPTH; j++) begin
        if (IW'(j) != free_idx) older_d[j][free_idx] = 1'b1;
      end
    end

    if (alloc_fire && !issue_fire)      count_d = count_q + CW'(1);
    else if (!alloc_fire && issue_fire) count_d = count_q - CW'(1);

    if (flush) begin
      busy_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q  <= '0;
      rdy1_q  <= '0;
      rdy2_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ctrl_q[i]  <= '0;
        dest_q[i]  <= '0;
        v1_q[i]    <= '0;
        v2_q[i]    <= '0;
        t1_q[i]    <= '0;
        t2_q[i]    <= '0;
        older_q[i] <= '0;
      end
    end else begin
      busy_q  <= busy_d;
      rdy1_q  <= rdy1_d;
      rdy2_q  <= rdy2_d;
      count_q <= count_d;
      ctrl_q  <= ctrl_d;
      dest_q  <= dest_d;
      v1_q    <= v1_d;
      v2_q    <= v2_d;
      t1_q    <= t1_d;
      t2_q    <= t2_d;
      older_q <= older_d;
    end
  end

  assign issue_valid = sel_found;
  assign issue_ctrl  = sel_found ? ctrl_q[sel_idx] : '0;
  assign issue_dest  = sel_found ? dest_q[sel_idx] : '0;
  assign issue_v1    = sel_found ? v1_q[sel_idx]   : '0;
  assign issue_v2    = sel_found ? v2_q[sel_idx]   : '0;
  assign count       = count_q;
  assign empty       = (count_q == '0);

endmodule
